// File: rtl/vga_rect_plotter_if.sv
// Command and pixel-write bundle between a rectangle requester and vga_rect_plotter.
// The master issues commands and observes pixels; the slave is the plotter.
interface vga_rect_plotter_if #(
   parameter int XW = 8,
   parameter int YW = 7,
   parameter int CW = 3
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [XW-1:0] cmd_x;
   logic [YW-1:0] cmd_y;
   logic [XW-1:0] cmd_w;
   logic [YW-1:0] cmd_h;
   logic [CW-1:0] cmd_color;
   logic [1:0]    cmd_mode;
   logic          abort;
   logic [XW-1:0] VGA_X;
   logic [YW-1:0] VGA_Y;
   logic [CW-1:0] VGA_COLOR;
   logic          plot;
   logic          busy;
   logic          done;

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_mode, abort,
      input  cmd_ready, VGA_X, VGA_Y, VGA_COLOR, plot, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_mode, abort,
      output cmd_ready, VGA_X, VGA_Y, VGA_COLOR, plot, busy, done
   );
endinterface

// File: rtl/vga_rect_plotter.sv
// Rectangle plotter: walks a latched rectangle one pixel per cycle in row-major
// order and drives a VGA adapter pixel-write port (fill / outline / clear).
module vga_rect_plotter #(
   parameter int XW    = 8,
   parameter int YW    = 7,
   parameter int CW    = 3,
   parameter int H_RES = 160,
   parameter int V_RES = 120
) (
   input  logic            CLOCK_50,
   input  logic            resetn,
   vga_rect_plotter_if.slave bus
);
   typedef enum logic {IDLE, DRAW} state_t;
   localparam logic [1:0] MODE_OUTLINE = 2'b01;
   localparam logic [1:0] MODE_CLEAR   = 2'b10;

   state_t        state, state_nxt;
   logic [XW-1:0] x0_q, w_q, dx_q;
   logic [YW-1:0] y0_q, h_q, dy_q;
   logic [CW-1:0] color_q;
   logic          outline_q;

   logic          accept, degenerate, last_pix;
   logic [XW-1:0] px0, pw, pdx;
   logic [YW-1:0] py0, ph, pdy;
   logic [CW-1:0] pcolor;
   logic          poutline;
   logic [XW:0]   sx;
   logic [YW:0]   sy;
   logic          clipped, on_edge, plot_d, done_d;

   assign accept     = bus.cmd_valid & bus.cmd_ready;
   assign degenerate = (bus.cmd_mode != MODE_CLEAR) && (bus.cmd_w == '0 || bus.cmd_h == '0);
   assign last_pix   = (dx_q == w_q - XW'(1)) && (dy_q == h_q - YW'(1));

   // State register plus the latched command and pixel counters
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         dx_q      <= '0;
         dy_q      <= '0;
         x0_q      <= '0;
         y0_q      <= '0;
         w_q       <= '0;
         h_q       <= '0;
         color_q   <= '0;
         outline_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt == DRAW) begin
            dx_q <= pdx;
            dy_q <= pdy;
         end else begin
            dx_q <= '0;
            dy_q <= '0;
         end
         if (accept) begin
            x0_q      <= px0;
            y0_q      <= py0;
            w_q       <= pw;
            h_q       <= ph;
            color_q   <= pcolor;
            outline_q <= poutline;
         end
      end
   end

   // Abort wins over completion when both land in the same cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && !degenerate) state_nxt = DRAW;
         DRAW:    if (bus.abort || last_pix) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next pixel: from the incoming command on accept, else the advanced counters
   always_comb begin
      px0      = x0_q;
      py0      = y0_q;
      pw       = w_q;
      ph       = h_q;
      pcolor   = color_q;
      poutline = outline_q;
      pdx      = dx_q;
      pdy      = dy_q;
      if (state == IDLE) begin
         pdx    = '0;
         pdy    = '0;
         pcolor = bus.cmd_color;
         if (bus.cmd_mode == MODE_CLEAR) begin
            px0      = '0;
            py0      = '0;
            pw       = XW'(H_RES);
            ph       = YW'(V_RES);
            poutline = 1'b0;
         end else begin
            px0      = bus.cmd_x;
            py0      = bus.cmd_y;
            pw       = bus.cmd_w;
            ph       = bus.cmd_h;
            poutline = (bus.cmd_mode == MODE_OUTLINE);
         end
      end else if (dx_q == w_q - XW'(1)) begin
         pdx = '0;
         pdy = dy_q + YW'(1);
      end else begin
         pdx = dx_q + XW'(1);
      end
      // One extra bit so off-screen sums are seen rather than wrapping on-screen
      sx      = {1'b0, px0} + {1'b0, pdx};
      sy      = {1'b0, py0} + {1'b0, pdy};
      clipped = (sx >= (XW+1)'(H_RES)) || (sy >= (YW+1)'(V_RES));
      on_edge = (pdx == '0) || (pdx == pw - XW'(1)) || (pdy == '0) || (pdy == ph - YW'(1));
      plot_d  = (state_nxt == DRAW) && !clipped && (!poutline || on_edge);
      done_d  = (state == IDLE) ? (accept && degenerate) : (!bus.abort && last_pix);
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         bus.cmd_ready <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.plot      <= 1'b0;
         bus.VGA_X     <= '0;
         bus.VGA_Y     <= '0;
         bus.VGA_COLOR <= '0;
      end else begin
         bus.cmd_ready <= (state_nxt == IDLE);
         bus.busy      <= (state_nxt == DRAW);
         bus.done      <= done_d;
         bus.plot      <= plot_d;
         if (state_nxt == DRAW) begin
            bus.VGA_X     <= sx[XW-1:0];
            bus.VGA_Y     <= sy[YW-1:0];
            bus.VGA_COLOR <= pcolor;
         end
      end
   end
endmodule

// File: tb/tb_vga_rect_plotter.sv
// Scoreboard bench for vga_rect_plotter: directed commands push hand-computed
// pixel/done events; a negedge monitor pops and compares each busy/done cycle.
module tb_vga_rect_plotter;
   localparam int XW = 8;
   localparam int YW = 7;
   localparam int CW = 3;

   typedef struct packed {
      logic          pix;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [CW-1:0] c;
      logic          plot;
      logic          done;
      logic          busy;
      logic          ready;
   } exp_t;

   logic CLOCK_50 = 1'b0;
   logic resetn   = 1'b1;
   always #5 CLOCK_50 = ~CLOCK_50;

   vga_rect_plotter_if #(.XW(XW), .YW(YW), .CW(CW)) bus();

   vga_rect_plotter #(.XW(XW), .YW(YW), .CW(CW), .H_RES(160), .V_RES(120)) dut (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .bus      (bus)
   );

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   exp_t mon_e;
   logic mon_bad;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic exp_pix(input int x, input int y, input int c, input bit p);
      exp_t e;
      e.pix = 1'b1; e.x = XW'(x); e.y = YW'(y); e.c = CW'(c);
      e.plot = p; e.done = 1'b0; e.busy = 1'b1; e.ready = 1'b0;
      q.push_back(e);
   endtask

   task automatic exp_done();
      exp_t e;
      e.pix = 1'b0; e.x = '0; e.y = '0; e.c = '0;
      e.plot = 1'b0; e.done = 1'b1; e.busy = 1'b0; e.ready = 1'b1;
      q.push_back(e);
   endtask

   // Offer a command, let it be taken on the next edge, then scramble the fields
   task automatic send(input int x, input int y, input int w, input int h, input int c, input int m);
      bus.cmd_x = XW'(x); bus.cmd_y = YW'(y); bus.cmd_w = XW'(w); bus.cmd_h = YW'(h);
      bus.cmd_color = CW'(c); bus.cmd_mode = 2'(m); bus.cmd_valid = 1'b1;
      @(posedge CLOCK_50); #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_x = XW'($urandom); bus.cmd_y = YW'($urandom); bus.cmd_w = XW'($urandom);
      bus.cmd_h = YW'($urandom); bus.cmd_color = CW'($urandom); bus.cmd_mode = 2'($urandom);
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (bus.done !== 1'b1 && n < budget) begin
         @(posedge CLOCK_50); #1;
         n++;
      end
      if (bus.done !== 1'b1) begin
         tests++; fails++;
         $display("FAIL %s_timeout: done=0 after %0d cycles, required done=1", name, budget);
      end
   endtask

   always @(negedge CLOCK_50) begin
      tests++;
      if (bus.busy === 1'b1 || bus.done === 1'b1) begin
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output: busy=%b done=%b plot=%b x=%0d y=%0d, required no event",
                     bus.busy, bus.done, bus.plot, bus.VGA_X, bus.VGA_Y);
         end else begin
            mon_e   = q.pop_front();
            mon_bad = (bus.plot !== mon_e.plot) || (bus.done !== mon_e.done) ||
                      (bus.busy !== mon_e.busy) || (bus.cmd_ready !== mon_e.ready) ||
                      (mon_e.pix && ((bus.VGA_X !== mon_e.x) || (bus.VGA_Y !== mon_e.y) ||
                                     (bus.VGA_COLOR !== mon_e.c)));
            if (mon_bad) begin
               fails++;
               $display("FAIL pixel_event: got x=%0d y=%0d c=%0d plot=%b done=%b busy=%b ready=%b, required x=%0d y=%0d c=%0d plot=%b done=%b busy=%b ready=%b (pix=%b)",
                        bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR, bus.plot, bus.done, bus.busy, bus.cmd_ready,
                        mon_e.x, mon_e.y, mon_e.c, mon_e.plot, mon_e.done, mon_e.busy, mon_e.ready, mon_e.pix);
            end
         end
      end else if (bus.plot !== 1'b0) begin
         fails++;
         $display("FAIL idle_plot: got plot=%b while idle, required 0", bus.plot);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid = 1'b0; bus.abort = 1'b0;
      bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0;
      bus.cmd_color = '0; bus.cmd_mode = '0;
      #1 resetn = 1'b0;
      #1;
      chk("rst_ready", bus.cmd_ready, 0);
      chk("rst_busy",  bus.busy, 0);
      chk("rst_done",  bus.done, 0);
      chk("rst_plot",  bus.plot, 0);
      chk("rst_x",     bus.VGA_X, 0);
      chk("rst_y",     bus.VGA_Y, 0);
      chk("rst_color", bus.VGA_COLOR, 0);
      repeat (2) @(posedge CLOCK_50);
      #3 resetn = 1'b1;
      @(posedge CLOCK_50); #1;
      chk("ready_after_rst", bus.cmd_ready, 1);

      // Basic 3x2 fill
      exp_pix(10, 20, 5, 1); exp_pix(11, 20, 5, 1); exp_pix(12, 20, 5, 1);
      exp_pix(10, 21, 5, 1); exp_pix(11, 21, 5, 1); exp_pix(12, 21, 5, 1);
      exp_done();
      send(10, 20, 3, 2, 5, 0);
      wait_done("fill", 20);

      // Issued in the done cycle: right-edge clipping
      exp_pix(158, 0, 6, 1); exp_pix(159, 0, 6, 1); exp_pix(160, 0, 6, 0); exp_pix(161, 0, 6, 0);
      exp_done();
      send(158, 0, 4, 1, 6, 0);
      wait_done("clip_x", 20);

      // 3x3 outline: only the centre pixel is dark
      exp_pix(0, 0, 3, 1); exp_pix(1, 0, 3, 1); exp_pix(2, 0, 3, 1);
      exp_pix(0, 1, 3, 1); exp_pix(1, 1, 3, 0); exp_pix(2, 1, 3, 1);
      exp_pix(0, 2, 3, 1); exp_pix(1, 2, 3, 1); exp_pix(2, 2, 3, 1);
      exp_done();
      send(0, 0, 3, 3, 3, 1);
      wait_done("outline", 20);

      // Degenerate commands: done in the cycle after accept, never busy
      exp_done();
      send(30, 30, 0, 5, 4, 0);
      chk("degen_w_done", bus.done, 1);
      chk("degen_w_busy", bus.busy, 0);
      exp_done();
      send(1, 1, 5, 0, 4, 1);
      chk("degen_h_done", bus.done, 1);

      // Mode 11 behaves as fill
      exp_pix(100, 100, 7, 1); exp_pix(101, 100, 7, 1);
      exp_done();
      send(100, 100, 2, 1, 7, 3);
      wait_done("mode3", 20);

      // Bottom-edge clipping
      exp_pix(0, 118, 1, 1); exp_pix(0, 119, 1, 1); exp_pix(0, 120, 1, 0);
      exp_done();
      send(0, 118, 1, 3, 1, 0);
      wait_done("clip_y", 20);

      // Clear ignores geometry (w=0 here must not be degenerate)
      for (int y = 0; y < 120; y++)
         for (int x = 0; x < 160; x++)
            exp_pix(x, y, 2, 1);
      exp_done();
      send(77, 9, 0, 0, 2, 2);
      wait_done("clear", 20000);

      // Abort during the third pixel of a 4x4 fill
      exp_pix(40, 50, 7, 1); exp_pix(41, 50, 7, 1); exp_pix(42, 50, 7, 1);
      send(40, 50, 4, 4, 7, 0);
      @(posedge CLOCK_50); #1;
      @(posedge CLOCK_50); #1;
      bus.abort = 1'b1;
      @(posedge CLOCK_50); #1;
      bus.abort = 1'b0;
      chk("abort_plot",  bus.plot, 0);
      chk("abort_done",  bus.done, 0);
      chk("abort_busy",  bus.busy, 0);
      chk("abort_ready", bus.cmd_ready, 1);

      // Asynchronous reset in the middle of a fill
      exp_pix(20, 30, 4, 1); exp_pix(21, 30, 4, 1);
      send(20, 30, 4, 4, 4, 0);
      @(posedge CLOCK_50); #6;
      resetn = 1'b0;
      #1;
      chk("midrst_plot",  bus.plot, 0);
      chk("midrst_busy",  bus.busy, 0);
      chk("midrst_ready", bus.cmd_ready, 0);
      chk("midrst_done",  bus.done, 0);
      repeat (2) @(posedge CLOCK_50);
      #3 resetn = 1'b1;
      @(posedge CLOCK_50); #1;
      chk("midrst_ready_after", bus.cmd_ready, 1);

      // 1x1 fill offered with abort high while idle: abort must be ignored
      exp_pix(5, 6, 1, 1);
      exp_done();
      bus.abort = 1'b1;
      send(5, 6, 1, 1, 1, 0);
      bus.abort = 1'b0;
      wait_done("one_pixel", 20);

      repeat (4) @(posedge CLOCK_50);
      #1;
      chk("queue_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/vga_rect_plotter.md
VGA_RECT_PLOTTER -- requirements
Module: vga_rect_plotter

Interface
REQ-001 Parameter XW, default 8, VGA x bitwidth (10 for 640x480, 9 for 320x240, 8 for 160x120).
REQ-002 Parameter YW, default 7, VGA y bitwidth (9 / 8 / 7 for the same resolutions).
REQ-003 Parameter CW, default 3, color bitwidth.
REQ-004 Parameter H_RES, default 160, visible columns; V_RES, default 120, visible rows.
REQ-005 CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-006 resetn  in  1  reset, asynchronous, active-low.
REQ-007 cmd_valid  in  1  command offered; cmd_ready  out  1  block accepts command.
REQ-008 cmd_x  in  XW, cmd_y  in  YW  top-left corner.
REQ-009 cmd_w  in  XW, cmd_h  in  YW  rectangle width and height in pixels.
REQ-010 cmd_color  in  CW  pixel color; cmd_mode  in  2  00 fill, 01 outline, 10 clear, 11 treated as fill.
REQ-011 abort  in  1  synchronous cancel of the current command.
REQ-012 VGA_X  out  XW, VGA_Y  out  YW, VGA_COLOR  out  CW, plot  out  1  pixel write port to the VGA adapter.
REQ-013 busy  out  1  command in progress; done  out  1  one-cycle completion pulse.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have states IDLE and DRAW; cmd_ready SHALL equal 1 exactly in IDLE; busy SHALL equal 1 exactly in DRAW.
REQ-016 Handshake: a command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1; all cmd_* fields are latched on that edge; cmd_* changes afterwards have no effect.
REQ-017 On acceptance with mode fill/outline and cmd_w=0 or cmd_h=0: the block SHALL stay in IDLE, emit no plot, and assert done in the cycle following the accept edge.
REQ-018 Otherwise it SHALL enter DRAW and present the first pixel in the cycle following the accept edge (latency 1).
REQ-019 DRAW visits one pixel per cycle in row-major order: dx from 0 to w-1 (fastest), then dy from 0 to h-1; VGA_X=x0+dx, VGA_Y=y0+dy; VGA_COLOR=latched color.
REQ-020 Coordinate sums SHALL be computed at XW+1 / YW+1 bits; a pixel with sum >= H_RES or >= V_RES is clipped: it still uses its cycle, with plot=0; VGA_X/VGA_Y carry the truncated sum.
REQ-021 Fill mode: plot=1 for every unclipped pixel.
REQ-022 Outline mode: plot=1 only for unclipped pixels with dx=0, dx=w-1, dy=0 or dy=h-1; interior pixels use their cycle with plot=0.
REQ-023 Clear mode: cmd_x/y/w/h are ignored; the block visits (0,0)..(H_RES-1,V_RES-1), H_RES*V_RES cycles, all with plot=1.
REQ-024 After the last pixel cycle the block SHALL return to IDLE and assert done for exactly one cycle, with plot=0 in that cycle.
REQ-025 Because cmd_ready=1 in the done cycle, a new command may be accepted in that cycle; its first pixel follows on the next cycle (back-to-back with one gap cycle).
REQ-026 Abort=1 in DRAW: on the next edge the block SHALL go to IDLE with plot=0 and no done pulse; abort in IDLE is ignored, and abort takes priority over completion in the same cycle.
REQ-027 plot SHALL be 0 in every cycle spent in IDLE.

Reset
REQ-028 resetn=0 SHALL immediately, without waiting for a clock edge, force IDLE, cmd_ready=0 while asserted, busy=0, done=0, plot=0, VGA_X=0, VGA_Y=0, VGA_COLOR=0, and clear all counters.
REQ-029 Reset mid-DRAW SHALL discard the command with no done pulse; cmd_ready=1 on the first edge after resetn rises.

Verification
REQ-030 Fill x=10,y=20,w=3,h=2,color=5 -> 6 plot cycles (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) with color 5, then done=1 for 1 cycle.
REQ-031 Clip with H_RES=160: fill x=158,y=0,w=4,h=1 -> 4 cycles; plot=1 at x=158 and 159 only; done follows.
REQ-032 Outline x=0,y=0,w=3,h=3 -> 9 cycles; plot=0 only at (1,1). Degenerate command w=0 -> no plot, done in the cycle after accept.
REQ-033 Clear with color=2 -> 19200 consecutive plot cycles, last at (159,119); done on the next cycle; cmd_ready=0 throughout.
REQ-034 Abort asserted in the 3rd pixel cycle of a 4x4 fill -> plot=0 from the next cycle, no done, cmd_ready=1 on the next cycle.
REQ-035 resetn pulled low mid-fill between edges -> plot and busy drop to 0 immediately; after release a new 1x1 fill produces 1 plot cycle and then done.
